mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Responder side of the byte-wide memory protocol driven by the instruction fetch unit.
- Owns the single 8-bit RAM/IO port.
- Arbitrates between the fetch byte stream and multi-byte load/store transactions from the LSB.
- Returns per-byte grants and data to fetch, and assembled words plus a done pulse to the LSB.

Parameters:
ADDR_W, 32, address width of all address ports
IO_BASE, 32'h30000, lowest address treated as IO (used by the optional feature)

Ports:
clk_in  input  1  clock
rst_n_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global enable; low freezes all state
mem_din  input  8  RAM read data; valid the cycle after its address
mem_dout  output  8  RAM write data
mem_a  output  ADDR_W  RAM address
mem_wr  output  1  RAM write strobe (1 = write)
io_buffer_full  input  1  IO transmit buffer full
if_req  input  1  fetch wants a byte this cycle
if_addr  input  ADDR_W  fetch byte address
change_pc  input  1  fetch flush; cancels this cycle's fetch grant
mem_rdy  output  1  fetch byte at if_addr issued this cycle; data on mem_byte next cycle
mem_byte  output  8  byte returned to fetch (= mem_din)
mem_is_writing  output  1  last cycle's fetch grant revoked; fetch must discard and rewind by 1
lsb_req  input  1  LSB request; held until lsb_done
lsb_we  input  1  1 = store, 0 = load
lsb_size  input  2  0 = byte, 1 = half, 2 or 3 = word
lsb_addr  input  ADDR_W  base address
lsb_wdata  input  32  store data, little-endian
lsb_busy  output  1  LSB transaction in progress
lsb_done  output  1  one-cycle completion pulse
lsb_rdata  output  32  load result, zero-extended, valid with lsb_done

Behaviour:
- Reset (async, rst_n_in=0):
  - State goes to IDLE; byte counter and shift register clear.
  - mem_a=0, mem_wr=0, mem_dout=0, mem_rdy=0, mem_is_writing=0, lsb_busy=0, lsb_done=0, lsb_rdata=0.
  - An in-flight LSB transaction is abandoned; no lsb_done is produced.
- rdy_in=0: all registers hold; mem_rdy=0, mem_wr=0.
- States: IDLE, LSB_RD, LSB_WR, LSB_DONE.
- IDLE:
  - If lsb_req: latch addr, size, wdata, we; set n = 1/2/4 bytes and i = 0; go to LSB_RD or LSB_WR. The first byte issues in the next cycle.
  - Else if if_req and change_pc=0: mem_a=if_addr, mem_wr=0, mem_rdy=1 (combinational).
  - mem_rdy is never asserted outside IDLE or when change_pc=1.
- mem_byte = mem_din at all times.
- mem_is_writing:
  - Registered; equals 1 for exactly one cycle, the cycle after lsb_req was accepted, if the previous cycle gave a fetch grant.
  - Fetch rewinds by one address and discards that byte.
- LSB_RD:
  - Each cycle: mem_a = addr+i, mem_wr=0; shift mem_din of the previous issue into byte lane i-1.
  - After issue n-1, one extra capture cycle, then LSB_DONE.
- LSB_WR:
  - Each cycle: mem_a = addr+i, mem_wr=1, mem_dout = wdata[8i+7:8i].
  - After issue n-1, go to LSB_DONE.
- LSB_DONE: lsb_done=1 and lsb_rdata valid for one cycle, then IDLE. Fetch is not granted this cycle.
- Latency, counted from the accept cycle A:
  - Load: lsb_done at A+n+2.
  - Store: lsb_done at A+n+1.
- lsb_busy = 1 from A+1 through the LSB_DONE cycle inclusive.
- Address arithmetic wraps modulo 2^ADDR_W.
- Unused lsb_rdata lanes are 0.
- change_pc during an LSB transaction has no effect on it.
- lsb_req deasserted mid-transaction: ignored; the transaction completes.
- Simultaneous lsb_req and if_req in IDLE: LSB wins; that cycle's fetch grant is still given.

Optional Feature:
IO_STALL_EN
- Defined: in LSB_WR, if the current byte address >= IO_BASE and io_buffer_full=1, hold the state with mem_wr=0 and i unchanged. Retry each cycle until io_buffer_full=0.
- Undefined: io_buffer_full is ignored.

Test Plan:
- Fetch stream: if_req=1, if_addr 0,1,2,3 with RAM[0..3]=13,00,00,00. Expect mem_rdy=1 each cycle; mem_byte 13,00,00,00 on the following cycles.
- Word load at 0x100 with RAM=44,33,22,11. Expect lsb_rdata=32'h11223344, lsb_done at A+6, mem_wr never 1.
- Half store addr 0x200, wdata 32'hAABBCCDD. Expect writes DD@0x200 then CC@0x201; lsb_done at A+3; RAM[0x202] unchanged.
- Fetch granted in cycle A with lsb_req in A. Expect mem_is_writing=1 at A+1 only and mem_rdy=0 from A+1 until lsb_done+1.
- change_pc=1 with if_req=1 in IDLE: mem_rdy=0. Assert rst_n_in=0 mid word load: outputs 0 immediately, no lsb_done afterward.
- IO_STALL_EN: byte store to 0x30000 with io_buffer_full=1 for 3 cycles. Expect mem_wr=0 for those cycles, then one write and lsb_done the next cycle.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Fetch and LSB request/response bundle between the requesters and mem_ctrl.
interface mem_ctrl_if #(parameter int ADDR_W = 32);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              change_pc;
    logic              mem_rdy;
    logic [7:0]        mem_byte;
    logic              mem_is_writing;
    logic              lsb_req;
    logic              lsb_we;
    logic [1:0]        lsb_size;
    logic [ADDR_W-1:0] lsb_addr;
    logic [31:0]       lsb_wdata;
    logic              lsb_busy;
    logic              lsb_done;
    logic [31:0]       lsb_rdata;

    modport master (
        output if_req, if_addr, change_pc, lsb_req, lsb_we, lsb_size, lsb_addr, lsb_wdata,
        input  mem_rdy, mem_byte, mem_is_writing, lsb_busy, lsb_done, lsb_rdata
    );
    modport slave (
        input  if_req, if_addr, change_pc, lsb_req, lsb_we, lsb_size, lsb_addr, lsb_wdata,
        output mem_rdy, mem_byte, mem_is_writing, lsb_busy, lsb_done, lsb_rdata
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO port owner: fetch byte stream vs. multi-byte LSB load/store.
// Optional IO_STALL_EN: hold stores to IO addresses while io_buffer_full is set.
module mem_ctrl #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = 'h30000
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    mem_ctrl_if.slave         bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] LSB_RD   = 2'd1;
    localparam logic [1:0] LSB_WR   = 2'd2;
    localparam logic [1:0] LSB_DONE = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] base;
    logic [2:0]        n, i;
    logic [31:0]       wdata, sreg;
    logic              is_wr_q;
    logic [ADDR_W-1:0] cur_a;
    logic              grant, accept, stall;
    logic [1:0]        lane;

    assign cur_a  = base + ADDR_W'(i);
    // Reset gates the combinational grant so the port is quiet during reset.
    assign grant  = rst_n_in & rdy_in & (state == IDLE) & bus.if_req & ~bus.change_pc;
    assign accept = rdy_in & (state == IDLE) & bus.lsb_req;
    assign lane   = 2'(i - 3'd1);

`ifdef IO_STALL_EN
    assign stall = (cur_a >= IO_BASE) & io_buffer_full;
`else
    assign stall = 1'b0;
    logic unused_io;
    assign unused_io = ^{io_buffer_full, IO_BASE};
`endif

    always_comb begin
        mem_a    = '0;
        mem_wr   = 1'b0;
        mem_dout = 8'h00;
        case (state)
            IDLE:    if (grant) mem_a = bus.if_addr;
            LSB_RD:  mem_a = cur_a;
            LSB_WR: begin
                mem_a    = cur_a;
                mem_wr   = rdy_in & ~stall;
                mem_dout = 8'(wdata >> {i[1:0], 3'b000});
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= IDLE;
            base    <= '0;
            n       <= 3'd0;
            i       <= 3'd0;
            wdata   <= 32'h0;
            sreg    <= 32'h0;
            is_wr_q <= 1'b0;
        end else if (rdy_in) begin
            // Fetch grant given in the accept cycle is revoked next cycle.
            is_wr_q <= accept & grant;
            case (state)
                IDLE: if (bus.lsb_req) begin
                    base  <= bus.lsb_addr;
                    wdata <= bus.lsb_wdata;
                    sreg  <= 32'h0;
                    i     <= 3'd0;
                    n     <= (bus.lsb_size == 2'd0) ? 3'd1 :
                             (bus.lsb_size == 2'd1) ? 3'd2 : 3'd4;
                    state <= bus.lsb_we ? LSB_WR : LSB_RD;
                end
                LSB_RD: begin
                    // Byte issued last cycle arrives now; i == n is the extra capture cycle.
                    if (i != 3'd0) sreg <= sreg | (32'(mem_din) << {lane, 3'b000});
                    if (i == n) state <= LSB_DONE;
                    else        i     <= i + 3'd1;
                end
                LSB_WR: if (!stall) begin
                    if (i == n - 3'd1) state <= LSB_DONE;
                    else               i     <= i + 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_rdy        = grant;
    assign bus.mem_byte       = mem_din;
    assign bus.mem_is_writing = is_wr_q;
    assign bus.lsb_busy       = (state != IDLE);
    assign bus.lsb_done       = (state == LSB_DONE);
    assign bus.lsb_rdata      = sreg;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed + random bench for mem_ctrl against a byte-array memory model.
module tb_mem_ctrl;
    localparam int ADDR_W = 32;

    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    mem_ctrl_if #(.ADDR_W(ADDR_W)) bus();

    mem_ctrl #(.ADDR_W(ADDR_W), .IO_BASE(32'h30000)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .bus(bus)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous RAM: read data valid the cycle after the address.
    logic [7:0]  ram [0:4095];
    logic        ld_en;
    logic [11:0] ld_a;
    logic [7:0]  ld_d;
    always @(posedge clk_in) begin
        if (ld_en)       ram[ld_a] <= ld_d;
        else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    logic [7:0] shadow [0:4095];
    int ncmp = 0, nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic lsb_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, input logic fetch, input int io_full);
        int n, stall, exp_lat, c, nwr;
        logic done;
        logic [31:0] exp_rd;
        logic [11:0] idx;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        stall = 0;
`ifdef IO_STALL_EN
        if (addr >= 32'h30000) stall = io_full;
`endif
        exp_lat = n + (we ? 1 : 2) + stall;
        exp_rd = 32'h0;
        for (int j = 0; j < n; j++) begin
            idx = 12'(addr + 32'(j));
            exp_rd = exp_rd | (32'(shadow[idx]) << (8 * j));
        end
        bus.lsb_req = 1'b1; bus.lsb_we = we; bus.lsb_size = size;
        bus.lsb_addr = addr; bus.lsb_wdata = wd;
        bus.if_req = fetch; bus.if_addr = 32'($urandom_range(0, 4095));
        #1 chk("grant_in_accept", 32'(bus.mem_rdy), 32'(fetch));
        c = 0; nwr = 0; done = 1'b0;
        while (!done && c < 40) begin
            @(posedge clk_in); #1;
            c++;
            io_buffer_full = (c <= io_full);
            #1;
            chk("is_writing", 32'(bus.mem_is_writing), (c == 1) ? 32'(fetch) : 32'h0);
            chk("rdy_while_busy", 32'(bus.mem_rdy), 32'h0);
            chk("busy", 32'(bus.lsb_busy), 32'h1);
            if (c <= stall) chk("io_hold", 32'(mem_wr), 32'h0);
            if (mem_wr) begin
                chk("wr_addr", mem_a, addr + 32'(nwr));
                chk("wr_data", 32'(mem_dout), (wd >> (8 * nwr)) & 32'hff);
                nwr++;
            end
            if (bus.lsb_done) done = 1'b1;
        end
        chk("latency", 32'(c), 32'(exp_lat));
        if (!we) chk("rdata", bus.lsb_rdata, exp_rd);
        chk("write_count", 32'(nwr), we ? 32'(n) : 32'h0);
        bus.lsb_req = 1'b0; io_buffer_full = 1'b0;
        cyc();
        chk("rdy_after_done", 32'(bus.mem_rdy), 32'(fetch));
        chk("idle_after_done", 32'(bus.lsb_busy), 32'h0);
        bus.if_req = 1'b0;
        if (we) begin
            for (int j = 0; j < n; j++) begin
                idx = 12'(addr + 32'(j));
                shadow[idx] = 8'(wd >> (8 * j));
            end
            for (int j = 0; j <= n; j++) begin
                idx = 12'(addr + 32'(j));
                chk("ram_after_store", 32'(ram[idx]), 32'(shadow[idx]));
            end
        end
    endtask

    initial begin
        int seen;
        rst_n_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; ld_en = 1'b0;
        ld_a = '0; ld_d = '0;
        bus.if_req = 1'b1; bus.if_addr = 32'h55; bus.change_pc = 1'b0;
        bus.lsb_req = 1'b0; bus.lsb_we = 1'b0; bus.lsb_size = 2'd0;
        bus.lsb_addr = '0; bus.lsb_wdata = '0;
        #3;
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_mem_dout", 32'(mem_dout), 32'h0);
        chk("rst_mem_rdy", 32'(bus.mem_rdy), 32'h0);
        chk("rst_is_writing", 32'(bus.mem_is_writing), 32'h0);
        chk("rst_busy", 32'(bus.lsb_busy), 32'h0);
        chk("rst_done", 32'(bus.lsb_done), 32'h0);
        chk("rst_rdata", bus.lsb_rdata, 32'h0);
        bus.if_req = 1'b0;

        for (int a = 0; a < 4096; a++) shadow[a] = 8'($urandom);
        shadow[0] = 8'h13; shadow[1] = 8'h00; shadow[2] = 8'h00; shadow[3] = 8'h00;
        shadow[12'h100] = 8'h44; shadow[12'h101] = 8'h33;
        shadow[12'h102] = 8'h22; shadow[12'h103] = 8'h11;
        ld_en = 1'b1;
        for (int a = 0; a < 4096; a++) begin
            ld_a = 12'(a); ld_d = shadow[a];
            cyc();
        end
        ld_en = 1'b0;
        rst_n_in = 1'b1;
        cyc();

        // Fetch stream, directed then random addresses.
        for (int k = 0; k < 10; k++) begin
            bus.if_req = 1'b1;
            bus.if_addr = (k < 4) ? 32'(k) : 32'($urandom_range(0, 4095));
            #1;
            chk("fetch_rdy", 32'(bus.mem_rdy), 32'h1);
            chk("fetch_addr", mem_a, bus.if_addr);
            cyc();
            chk("fetch_byte", 32'(bus.mem_byte), 32'(shadow[bus.if_addr[11:0]]));
        end

        bus.change_pc = 1'b1;
        #1 chk("change_pc_blocks", 32'(bus.mem_rdy), 32'h0);
        bus.change_pc = 1'b0; rdy_in = 1'b0;
        #1 chk("rdy_low_blocks", 32'(bus.mem_rdy), 32'h0);
        rdy_in = 1'b1; bus.if_req = 1'b0;
        cyc();

        lsb_txn(1'b0, 2'd2, 32'h100, 32'h0, 1'b0, 0);
        lsb_txn(1'b1, 2'd1, 32'h200, 32'hAABBCCDD, 1'b0, 0);
        lsb_txn(1'b0, 2'd2, 32'h104, 32'h0, 1'b1, 0);
        lsb_txn(1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0, 1'b0, 0);
        lsb_txn(1'b1, 2'd3, 32'hFFFF_FFFF, $urandom, 1'b1, 0);
        lsb_txn(1'b0, 2'd0, 32'h3, 32'h0, 1'b1, 0);
        lsb_txn(1'b1, 2'd0, 32'h30000, $urandom, 1'b0, 3);
        for (int k = 0; k < 20; k++)
            lsb_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                    $urandom, 1'($urandom_range(0, 1)), 0);

        // Reset in the middle of a word load abandons it.
        bus.lsb_req = 1'b1; bus.lsb_we = 1'b0; bus.lsb_size = 2'd2; bus.lsb_addr = 32'h100;
        cyc(); cyc();
        rst_n_in = 1'b0; bus.lsb_req = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.lsb_busy), 32'h0);
        chk("midrst_mem_a", mem_a, 32'h0);
        chk("midrst_rdata", bus.lsb_rdata, 32'h0);
        cyc();
        rst_n_in = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (bus.lsb_done) seen++;
        end
        chk("midrst_no_done", 32'(seen), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
